// File: rtl/csi2rx_five_lane_lml_pkg.sv
// Shared sizing, FSM encoding and small helpers for the CSI-2 RX five-lane merge layer.
package csi2rx_five_lane_lml_pkg;

    localparam int         NUM_LANES    = 5;
    localparam int         FIFO_DW      = 64;
    localparam int         CRC_BYTES    = 2;
    localparam logic [5:0] SHORT_DT_MAX = 6'h0F;

    typedef enum logic [2:0] {
        LML_IDLE      = 3'd0,
        LML_HDR       = 3'd1,
        LML_PAYLOAD   = 3'd2,
        LML_FLUSH     = 3'd3,
        LML_WAIT_STOP = 3'd4
    } lml_state_e;

    function automatic logic [2:0] popcnt5(input logic [4:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 5; i++) c = c + {2'b00, v[i]};
        return c;
    endfunction

    // Legal valid masks are thermometers from lane0: v & (v+1) clears exactly those.
    function automatic logic vld_thermo(input logic [4:0] v);
        return (v & (v + 5'd1)) == 5'd0;
    endfunction

    function automatic logic [7:0] therm_be(input logic [3:0] n);
        return 8'((9'd1 << n) - 9'd1);
    endfunction

endpackage

// File: rtl/csi2rx_five_lane_lml_if.sv
// PHY receive lanes, RX byte FIFO write port and packet status of the five-lane merge layer.
interface csi2rx_five_lane_lml_if;
    import csi2rx_five_lane_lml_pkg::*;

    logic [NUM_LANES-1:0]   rxactivehs;
    logic [NUM_LANES-1:0]   rxsynchs;
    logic [NUM_LANES-1:0]   rxvalidhs;
    logic [8*NUM_LANES-1:0] rxdatahs;
    logic                   fifo_full;
    logic                   fifo_wr_en;
    logic [FIFO_DW-1:0]     fifo_wr_data;
    logic [FIFO_DW/8-1:0]   fifo_wr_be;
    logic                   fifo_wr_eop;
    logic                   header_info;
    logic [31:0]            pkt_hdr;
    logic                   rx_done;
    logic                   lane_err;
    logic                   fifo_ovf_err;
    logic                   trunc_err;

    modport master (
        input  rxactivehs, rxsynchs, rxvalidhs, rxdatahs, fifo_full,
        output fifo_wr_en, fifo_wr_data, fifo_wr_be, fifo_wr_eop,
        output header_info, pkt_hdr, rx_done, lane_err, fifo_ovf_err, trunc_err
    );

    modport slave (
        output rxactivehs, rxsynchs, rxvalidhs, rxdatahs, fifo_full,
        input  fifo_wr_en, fifo_wr_data, fifo_wr_be, fifo_wr_eop,
        input  header_info, pkt_hdr, rx_done, lane_err, fifo_ovf_err, trunc_err
    );

endinterface

// File: rtl/csi2rx_byte_packer.sv
// Appends 0..5 bytes per cycle to a 0..7 byte residual and emits 64-bit words.
// Registered output one cycle after the completing beat; no backpressure (writer cannot stall).
module csi2rx_byte_packer
    import csi2rx_five_lane_lml_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [39:0] data,
    input  logic [2:0]  count,
    input  logic        last,
    input  logic        flush,
    input  logic        clr,
    output logic        wr,
    output logic [63:0] word,
    output logic [7:0]  be,
    output logic        eop
);

    logic [55:0] res;
    logic [2:0]  res_cnt;
    logic [39:0] dmask;
    logic [95:0] merged;
    logic [3:0]  total;

    always_comb begin
        dmask = '0;
        for (int i = 0; i < 5; i++) begin
            if (3'(i) < count) dmask[8*i +: 8] = data[8*i +: 8];
        end
        merged = {40'd0, res} | ({56'd0, dmask} << {res_cnt, 3'b000});
        total  = {1'b0, res_cnt} + {1'b0, count};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res     <= '0;
            res_cnt <= '0;
            wr      <= 1'b0;
            word    <= '0;
            be      <= '0;
            eop     <= 1'b0;
        end else begin
            wr  <= 1'b0;
            eop <= 1'b0;
            if (clr) begin
                res     <= '0;
                res_cnt <= '0;
            end else if (total >= 4'd8) begin
                // A full word closes the packet only if nothing is left behind.
                wr      <= 1'b1;
                word    <= merged[63:0];
                be      <= 8'hFF;
                eop     <= last && (total == 4'd8);
                res     <= {24'd0, merged[95:64]};
                res_cnt <= 3'(total - 4'd8);
            end else if (flush && total != 4'd0) begin
                wr      <= 1'b1;
                word    <= merged[63:0];
                be      <= therm_be(total);
                eop     <= 1'b1;
                res     <= '0;
                res_cnt <= '0;
            end else begin
                res     <= merged[55:0];
                res_cnt <= total[2:0];
            end
        end
    end

endmodule

// File: rtl/csi2rx_five_lane_lml.sv
// Merges five D-PHY byte lanes into the CSI-2 packet byte stream and packs it into 64-bit FIFO words.
// Words appear one cycle after the completing beat; fifo_full drops the write and flags overflow.
module csi2rx_five_lane_lml
    import csi2rx_five_lane_lml_pkg::*;
(
    input  logic                   rxbyteclkhs,
    input  logic                   rxbyteclkhs_rst_n,
    input  logic                   five_lane_en,
    csi2rx_five_lane_lml_if.master bus
);

    lml_state_e  state, state_nxt;
    logic [31:0] hdr_buf, hdr_nxt, hdr_shift, pkt_hdr_q;
    logic [2:0]  hdr_cnt, n, keep_pl, kept, pk_count;
    logic [3:0]  hdr_end, extra, keep_extra;
    logic [16:0] rem, rem_after, rem_hdr_nxt, rem_pl_nxt;
    logic        act0, vld_ok, lane_bad, hdr_done, done_now;
    logic        sync_go, take, pk_last, pk_flush, pk_clr, trunc;
    logic        pk_wr, pk_eop;
    logic [63:0] pk_word;
    logic [7:0]  pk_be;
    logic        header_info_q, rx_done_q, lane_err_q, ovf_err_q, trunc_err_q;

    always_comb begin
        act0      = bus.rxactivehs[0];
        vld_ok    = vld_thermo(bus.rxvalidhs);
        n         = popcnt5(bus.rxvalidhs);
        lane_bad  = !vld_ok || (act0 && bus.rxactivehs != 5'h1F);
        hdr_shift = bus.rxdatahs[31:0] << {hdr_cnt, 3'b000};
        hdr_end   = {1'b0, hdr_cnt} + {1'b0, n};
        hdr_nxt   = hdr_buf;
        for (int j = 0; j < 4; j++) begin
            if (4'(j) >= {1'b0, hdr_cnt} && 4'(j) < hdr_end)
                hdr_nxt[8*j +: 8] = hdr_shift[8*j +: 8];
        end
        hdr_done  = hdr_end >= 4'd4;
        // Bytes still owed after the header: WC plus CRC for long packets, in 17 bits so WC=FFFF cannot wrap.
        rem_after = (hdr_nxt[5:0] <= SHORT_DT_MAX) ? 17'd0
                                                   : {1'b0, hdr_nxt[23:8]} + 17'(CRC_BYTES);
        extra       = hdr_done ? hdr_end - 4'd4 : 4'd0;
        keep_extra  = ({13'd0, extra} > rem_after) ? rem_after[3:0] : extra;
        rem_hdr_nxt = rem_after - {13'd0, keep_extra};
        keep_pl     = ({14'd0, n} > rem) ? rem[2:0] : n;
        rem_pl_nxt  = rem - {14'd0, keep_pl};
        if (state == LML_HDR) begin
            kept     = hdr_done ? 3'(4'd4 - {1'b0, hdr_cnt} + keep_extra) : n;
            done_now = hdr_done && (rem_hdr_nxt == 17'd0);
        end else begin
            kept     = keep_pl;
            done_now = (rem_pl_nxt == 17'd0);
        end
    end

    always_ff @(posedge rxbyteclkhs or negedge rxbyteclkhs_rst_n) begin
        if (!rxbyteclkhs_rst_n) state <= LML_IDLE;
        else                    state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LML_IDLE: begin
                if (five_lane_en && bus.rxsynchs[0])
                    state_nxt = (bus.rxsynchs == 5'h1F) ? LML_HDR : LML_WAIT_STOP;
            end
            LML_HDR, LML_PAYLOAD: begin
                // A final byte arriving with lane0 already low still counts as a clean finish.
                if (lane_bad)                            state_nxt = LML_WAIT_STOP;
                else if (done_now)                       state_nxt = LML_FLUSH;
                else if (!act0)                          state_nxt = LML_IDLE;
                else if (state == LML_HDR && hdr_done)   state_nxt = LML_PAYLOAD;
            end
            LML_FLUSH:     state_nxt = LML_WAIT_STOP;
            LML_WAIT_STOP: if (!act0) state_nxt = LML_IDLE;
            default:       state_nxt = LML_IDLE;
        endcase
    end

    always_comb begin
        sync_go  = 1'b0;
        take     = 1'b0;
        pk_count = 3'd0;
        pk_last  = 1'b0;
        pk_flush = 1'b0;
        pk_clr   = 1'b0;
        trunc    = 1'b0;
        case (state)
            LML_IDLE: sync_go = five_lane_en && bus.rxsynchs[0];
            LML_HDR, LML_PAYLOAD: begin
                if (lane_bad) begin
                    pk_clr = 1'b1;
                end else if (done_now) begin
                    take     = 1'b1;
                    pk_count = kept;
                    pk_last  = 1'b1;
                end else if (!act0) begin
                    pk_flush = 1'b1;
                    trunc    = 1'b1;
                end else begin
                    take     = 1'b1;
                    pk_count = kept;
                end
            end
            LML_FLUSH: pk_flush = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge rxbyteclkhs or negedge rxbyteclkhs_rst_n) begin
        if (!rxbyteclkhs_rst_n) begin
            hdr_buf       <= '0;
            hdr_cnt       <= '0;
            rem           <= '0;
            pkt_hdr_q     <= '0;
            header_info_q <= 1'b0;
            rx_done_q     <= 1'b0;
            lane_err_q    <= 1'b0;
            ovf_err_q     <= 1'b0;
            trunc_err_q   <= 1'b0;
        end else begin
            header_info_q <= 1'b0;
            trunc_err_q   <= trunc;
            rx_done_q     <= (state == LML_WAIT_STOP) && !act0;
            if (state == LML_IDLE) begin
                hdr_cnt <= '0;
                rem     <= '0;
            end
            if (state == LML_HDR && take) begin
                hdr_buf <= hdr_nxt;
                hdr_cnt <= hdr_end[2:0];
                if (hdr_done) begin
                    pkt_hdr_q     <= hdr_nxt;
                    header_info_q <= 1'b1;
                    rem           <= rem_hdr_nxt;
                end
            end
            if (state == LML_PAYLOAD && take) rem <= rem_pl_nxt;
            if (sync_go)     lane_err_q <= (bus.rxsynchs != 5'h1F);
            else if (pk_clr) lane_err_q <= 1'b1;
            ovf_err_q <= (sync_go ? 1'b0 : ovf_err_q) | (pk_wr & bus.fifo_full);
        end
    end

    csi2rx_byte_packer u_packer (
        .clk   (rxbyteclkhs),
        .rst_n (rxbyteclkhs_rst_n),
        .data  (bus.rxdatahs),
        .count (pk_count),
        .last  (pk_last),
        .flush (pk_flush),
        .clr   (pk_clr),
        .wr    (pk_wr),
        .word  (pk_word),
        .be    (pk_be),
        .eop   (pk_eop)
    );

    assign bus.fifo_wr_en   = pk_wr && !bus.fifo_full;
    assign bus.fifo_wr_data = pk_word;
    assign bus.fifo_wr_be   = pk_be;
    assign bus.fifo_wr_eop  = pk_eop;
    assign bus.header_info  = header_info_q;
    assign bus.pkt_hdr      = pkt_hdr_q;
    assign bus.rx_done      = rx_done_q;
    assign bus.lane_err     = lane_err_q;
    assign bus.fifo_ovf_err = ovf_err_q;
    assign bus.trunc_err    = trunc_err_q;

endmodule

// File: tb/tb_csi2rx_five_lane_lml.sv
// Directed bench for the five-lane merge layer: packet shapes, lane errors, overflow and truncation.
module tb_csi2rx_five_lane_lml;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic full_next;
    logic [7:0] strm [0:63];

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] wq_dat [$];
    logic [7:0]  wq_be  [$];
    logic        wq_eop [$];
    int n_hdr   = 0;
    int n_done  = 0;
    int n_trunc = 0;

    always #5 clk = ~clk;

    csi2rx_five_lane_lml_if bus ();

    csi2rx_five_lane_lml dut (
        .rxbyteclkhs       (clk),
        .rxbyteclkhs_rst_n (rst_n),
        .five_lane_en      (en),
        .bus               (bus)
    );

    always @(negedge clk) begin
        if (bus.fifo_wr_en) begin
            wq_dat.push_back(bus.fifo_wr_data);
            wq_be.push_back(bus.fifo_wr_be);
            wq_eop.push_back(bus.fifo_wr_eop);
        end
        if (bus.header_info) n_hdr++;
        if (bus.rx_done)     n_done++;
        if (bus.trunc_err)   n_trunc++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] wdat(input int i);
        return (i < wq_dat.size()) ? wq_dat[i] : '1;
    endfunction

    function automatic logic [7:0] wbe(input int i);
        return (i < wq_be.size()) ? wq_be[i] : 8'hXX;
    endfunction

    function automatic logic weop(input int i);
        return (i < wq_eop.size()) ? wq_eop[i] : 1'bx;
    endfunction

    task automatic drive(input logic [4:0] act, input logic [4:0] sync,
                         input logic [4:0] vld, input logic [39:0] dat);
        @(posedge clk);
        #1;
        bus.rxactivehs = act;
        bus.rxsynchs   = sync;
        bus.rxvalidhs  = vld;
        bus.rxdatahs   = dat;
        bus.fifo_full  = full_next;
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) drive(5'h00, 5'h00, 5'h00, 40'd0);
    endtask

    task automatic beat(input int idx, input logic [4:0] vld);
        logic [39:0] d;
        for (int l = 0; l < 5; l++) d[8*l +: 8] = strm[idx + l];
        drive(5'h1F, 5'h00, vld, d);
    endtask

    task automatic set_stream(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc);
        for (int k = 0; k < 64; k++) strm[k] = 8'(k);
        strm[0] = di;
        strm[1] = wc[7:0];
        strm[2] = wc[15:8];
        strm[3] = ecc;
    endtask

    task automatic long40_beats(input int nbeats);
        for (int b = 0; b < nbeats; b++) beat(5 * b, 5'h1F);
    endtask

    int bw, bh, bd, bt;

    task automatic mark();
        bw = wq_dat.size();
        bh = n_hdr;
        bd = n_done;
        bt = n_trunc;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        full_next = 1'b0;
        bus.rxactivehs = '0;
        bus.rxsynchs   = '0;
        bus.rxvalidhs  = '0;
        bus.rxdatahs   = '0;
        bus.fifo_full  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en",  64'(bus.fifo_wr_en),   64'd0);
        check("rst_wr_dat", bus.fifo_wr_data,      64'd0);
        check("rst_be_eop", 64'({bus.fifo_wr_be, bus.fifo_wr_eop}), 64'd0);
        check("rst_hdr",    64'({bus.header_info, bus.pkt_hdr}), 64'd0);
        check("rst_flags",  64'({bus.rx_done, bus.lane_err, bus.fifo_ovf_err, bus.trunc_err}), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Short packet in one 4-byte beat.
        mark();
        drive(5'h1F, 5'h1F, 5'h00, 40'd0);
        drive(5'h1F, 5'h00, 5'h0F, 40'hEE_2A_00_00_01);
        drive(5'h1F, 5'h00, 5'h00, 40'd0);
        idle(3);
        check("short_nwr",   64'(wq_dat.size() - bw), 64'd1);
        check("short_dat",   wdat(bw), 64'h0000_0000_2A00_0001);
        check("short_be",    64'(wbe(bw)), 64'h0F);
        check("short_eop",   64'(weop(bw)), 64'd1);
        check("short_hinfo", 64'(n_hdr - bh), 64'd1);
        check("short_hdr",   64'(bus.pkt_hdr), 64'h2A00_0001);
        check("short_done",  64'(n_done - bd), 64'd1);
        check("short_err",   64'({bus.lane_err, bus.fifo_ovf_err}), 64'd0);

        // Long packet WC=34: 40 bytes in 8 full beats.
        set_stream(8'h2B, 16'd34, 8'h11);
        mark();
        drive(5'h1F, 5'h1F, 5'h00, 40'd0);
        long40_beats(8);
        drive(5'h1F, 5'h00, 5'h00, 40'd0);
        idle(3);
        check("long_nwr",  64'(wq_dat.size() - bw), 64'd5);
        check("long_w0",   wdat(bw),     64'h0706_0504_1100_222B);
        check("long_w2",   wdat(bw + 2), 64'h1716_1514_1312_1110);
        check("long_w4",   wdat(bw + 4), 64'h2726_2524_2322_2120);
        check("long_be",   64'({wbe(bw), wbe(bw + 1), wbe(bw + 2), wbe(bw + 3), wbe(bw + 4)}), 64'hFF_FFFF_FFFF);
        check("long_eop",  64'({weop(bw), weop(bw + 1), weop(bw + 2), weop(bw + 3), weop(bw + 4)}), 64'b00001);
        check("long_hdr",  64'(bus.pkt_hdr), 64'h1100_222B);
        check("long_done", 64'(n_done - bd), 64'd1);

        // Long packet WC=1: 7 bytes in 5+5, trailing 3 bytes dropped.
        set_stream(8'h2C, 16'd1, 8'h22);
        for (int k = 4; k < 10; k++) strm[k] = 8'(8'h40 + k);
        mark();
        drive(5'h1F, 5'h1F, 5'h00, 40'd0);
        beat(0, 5'h1F);
        beat(5, 5'h1F);
        drive(5'h1F, 5'h00, 5'h00, 40'd0);
        idle(3);
        check("wc1_nwr", 64'(wq_dat.size() - bw), 64'd1);
        check("wc1_dat", wdat(bw), 64'h0046_4544_2200_012C);
        check("wc1_be",  64'(wbe(bw)), 64'h7F);
        check("wc1_eop", 64'(weop(bw)), 64'd1);

        // Illegal valid mask mid-payload.
        set_stream(8'h2B, 16'd34, 8'h11);
        mark();
        drive(5'h1F, 5'h1F, 5'h00, 40'd0);
        long40_beats(2);
        beat(10, 5'b10101);
        idle(3);
        check("lerr_nwr",  64'(wq_dat.size() - bw), 64'd1);
        check("lerr_eop",  64'(weop(bw)), 64'd0);
        check("lerr_flag", 64'(bus.lane_err), 64'd1);
        check("lerr_done", 64'(n_done - bd), 64'd1);

        // fifo_full for the cycle in which word0 is presented.
        mark();
        drive(5'h1F, 5'h1F, 5'h00, 40'd0);
        long40_beats(2);
        full_next = 1'b1;
        beat(10, 5'h1F);
        full_next = 1'b0;
        for (int b = 3; b < 8; b++) beat(5 * b, 5'h1F);
        drive(5'h1F, 5'h00, 5'h00, 40'd0);
        idle(3);
        check("ovf_nwr",   64'(wq_dat.size() - bw), 64'd4);
        check("ovf_first", wdat(bw), 64'h0F0E_0D0C_0B0A_0908);
        check("ovf_eop",   64'(weop(bw + 3)), 64'd1);
        check("ovf_flags", 64'({bus.fifo_ovf_err, bus.lane_err}), 64'b10);

        // Truncation with 10 bytes remaining, then a short packet immediately after.
        mark();
        drive(5'h1F, 5'h1F, 5'h00, 40'd0);
        long40_beats(6);
        drive(5'h00, 5'h00, 5'h00, 40'd0);
        drive(5'h1F, 5'h1F, 5'h00, 40'd0);
        drive(5'h1F, 5'h00, 5'h0F, 40'hEE_2A_00_00_01);
        drive(5'h1F, 5'h00, 5'h00, 40'd0);
        idle(3);
        check("trn_nwr",   64'(wq_dat.size() - bw), 64'd5);
        check("trn_dat",   wdat(bw + 3), 64'h0000_1D1C_1B1A_1918);
        check("trn_be",    64'(wbe(bw + 3)), 64'h3F);
        check("trn_eop",   64'({weop(bw + 2), weop(bw + 3)}), 64'b01);
        check("trn_pulse", 64'(n_trunc - bt), 64'd1);
        check("trn_next",  64'({wbe(bw + 4), weop(bw + 4)}), 64'h1F);
        check("trn_done",  64'(n_done - bd), 64'd1);
        check("trn_ovf",   64'(bus.fifo_ovf_err), 64'd0);

        // Sync seen on only some lanes.
        mark();
        drive(5'h1F, 5'h0F, 5'h00, 40'd0);
        drive(5'h1F, 5'h00, 5'h0F, 40'hEE_2A_00_00_01);
        idle(3);
        check("sync_lerr",  64'(bus.lane_err), 64'd1);
        check("sync_hinfo", 64'(n_hdr - bh), 64'd0);
        check("sync_done",  64'(n_done - bd), 64'd1);

        // Disabled block ignores a packet.
        en = 1'b0;
        mark();
        drive(5'h1F, 5'h1F, 5'h00, 40'd0);
        drive(5'h1F, 5'h00, 5'h0F, 40'hEE_2A_00_00_01);
        drive(5'h1F, 5'h00, 5'h00, 40'd0);
        idle(3);
        check("dis_nwr",   64'(wq_dat.size() - bw), 64'd0);
        check("dis_hinfo", 64'(n_hdr - bh), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
